// File: rtl/fifo_stream_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_rd_pkg
// Description : Shared widths and the pointer-increment helper for the
//               FIFO read-side stream adapter.
//               Items: c_PTR_W (slot pointer width), c_CNT_W (occupancy
//               width), ptr_inc() (advance a slot pointer, 2 wraps to 0).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_rd_pkg;

    localparam int c_PTR_W = 2;
    localparam int c_CNT_W = 2;

    // The local buffer has three slots, so a pointer wraps from 2 back to 0.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_rd_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_rd_if
// Description : Bundle of the FIFO read port and the output stream of the
//               read-side adapter.
//               fifo_empty / fifo_rd_en / fifo_dout : FIFO read port
//               flush                               : discard held data
//               out_valid / out_ready / out_data    : output stream
//               buf_count                           : local occupancy
//               slave  modport : adapter view
//               master modport : environment (FIFO + consumer) view
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_rd_if
    import fifo_stream_rd_pkg::*;
#(
    parameter int DW = 104
);

    logic               fifo_empty;
    logic               fifo_rd_en;
    logic [DW-1:0]      fifo_dout;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [c_CNT_W-1:0] buf_count;

    modport slave (
        input  fifo_empty,
        input  fifo_dout,
        input  flush,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output buf_count
    );

    modport master (
        output fifo_empty,
        output fifo_dout,
        output flush,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  buf_count
    );

endinterface
`default_nettype wire

// File: rtl/fifo_stream_rd_reg_buf3.sv
`default_nettype none
// ============================================================================
// Module      : reg_buf3
// Description : Three-entry, DW-wide register file. One write port at the
//               tail slot, one combinational read port at the head slot.
//               clk, nreset        : clock, async active-low reset
//               wr_en, wr_ptr,
//               wr_data            : write port
//               rd_ptr, rd_data    : read port
// Revision    : 1.0 - initial release
// ============================================================================
module reg_buf3
    import fifo_stream_rd_pkg::*;
#(
    parameter int DW = 104
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               wr_en,
    input  logic [c_PTR_W-1:0] wr_ptr,
    input  logic [DW-1:0]      wr_data,
    input  logic [c_PTR_W-1:0] rd_ptr,
    output logic [DW-1:0]      rd_data
);

    logic [DW-1:0] r_mem [0:2];

    generate
        for (genvar i = 0; i < 3; i++) begin : g_entry
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_mem[i] <= '0;
                end else if (wr_en && (wr_ptr == c_PTR_W'(i))) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    endgenerate

    // Pointer value 3 never occurs; it folds onto the last slot.
    always_comb begin
        rd_data = r_mem[2];
        case (rd_ptr)
            2'd0:    rd_data = r_mem[0];
            2'd1:    rd_data = r_mem[1];
            default: rd_data = r_mem[2];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_rd.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_rd
// Description : Read-side adapter for a FIFO with one-cycle read latency.
//               Issues reads ahead of the consumer into a 3-entry local
//               buffer and presents the data as a valid/ready stream at
//               full throughput. The read request never depends on
//               out_ready.
//               clk    : clock, rising edge
//               nreset : asynchronous active-low reset
//               bus    : slave view of fifo_stream_rd_if (FIFO read port,
//                        flush, output stream, buffer occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_rd
    import fifo_stream_rd_pkg::*;
#(
    parameter int DW = 104
) (
    input  logic              clk,
    input  logic              nreset,
    fifo_stream_rd_if.slave   bus
);

    // Depth is tied to the one-cycle FIFO read latency, so it is not tunable.
    localparam logic [c_CNT_W:0] c_DEPTH = 3'd3;

    logic [c_CNT_W-1:0] r_occ;
    logic               r_pend;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;

    logic [c_CNT_W:0]   w_inflight;
    logic               w_rd_en;
    logic               w_capture;
    logic               w_valid;
    logic               w_pop;
    logic [DW-1:0]      w_head_data;

    // Entries held plus the read already in flight, with a carry bit so
    // 3 + 1 cannot wrap.
    assign w_inflight = {1'b0, r_occ} + {{c_CNT_W{1'b0}}, r_pend};

    // nreset gates the request so the FIFO sees no read while the adapter
    // is held in reset, whatever the FIFO's flag is doing.
    assign w_rd_en   = nreset & ~bus.fifo_empty & ~bus.flush & (w_inflight < c_DEPTH);
    assign w_capture = r_pend & ~bus.flush;
    assign w_valid   = (r_occ != '0);
    assign w_pop     = w_valid & bus.out_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_occ  <= '0;
            r_pend <= 1'b0;
            r_head <= '0;
            r_tail <= '0;
        end else if (bus.flush) begin
            // Returning read data and any same-cycle pop are dropped too.
            r_occ  <= '0;
            r_pend <= 1'b0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_pend <= w_rd_en;
            if (w_capture) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    reg_buf3 #(
        .DW      (DW)
    ) u_buf (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (w_capture),
        .wr_ptr  (r_tail),
        .wr_data (bus.fifo_dout),
        .rd_ptr  (r_head),
        .rd_data (w_head_data)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = w_valid;
    assign bus.out_data   = w_head_data;
    assign bus.buf_count  = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_rd
// Description : Directed testbench for fifo_stream_rd with a behavioural
//               one-cycle-latency FIFO feeding the adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_rd;

    localparam int DW      = 104;
    localparam int FIFO_SZ = 1024;

    logic clk    = 1'b0;
    logic nreset = 1'b1;

    always #5 clk = ~clk;

    fifo_stream_rd_if #(.DW(DW)) bus();

    fifo_stream_rd #(.DW(DW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    // ---------------- behavioural FIFO (shares nreset) ----------------
    logic [DW-1:0] fmem [0:FIFO_SZ-1];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic [DW-1:0] fdout;
    logic          tb_ready = 1'b0;
    logic          tb_flush = 1'b0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = fdout;
    assign bus.out_ready  = tb_ready;
    assign bus.flush      = tb_flush;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr <= wr_ptr;
            fdout  <= '0;
        end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fdout  <= fmem[rd_ptr % FIFO_SZ];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] obs[$];
    logic          s_rd_en;
    logic          s_valid;
    logic          pend_model = 1'b0;
    int            rd_cnt = 0;
    int            max_inflight = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_ptr % FIFO_SZ] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // One clock cycle: drive inputs mid low-phase, sample, then move to the
    // next low phase.
    task automatic cyc(input logic rdy, input logic fl);
        int inflight;
        tb_ready = rdy;
        tb_flush = fl;
        #1;
        s_rd_en = bus.fifo_rd_en;
        s_valid = bus.out_valid;
        if (bus.out_valid && rdy) obs.push_back(bus.out_data);
        rd_cnt   = rd_cnt + int'(s_rd_en);
        inflight = int'(bus.buf_count) + int'(pend_model);
        if (inflight > max_inflight) max_inflight = inflight;
        pend_model = s_rd_en;
        @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input string pfx, input logic [DW-1:0] base, input int n);
        int errs = 0;
        check({pfx, "_count"}, 128'(obs.size()), 128'(n));
        for (int i = 0; i < n && i < obs.size(); i++) begin
            if (obs[i] !== base + DW'(i)) errs++;
        end
        check({pfx, "_order"}, 128'(errs), 128'(0));
    endtask

    // Preload 0x1..0x5, release reset, and follow the first stream.
    task automatic release_and_check(input string pfx);
        @(negedge clk);
        #1;
        for (int k = 1; k <= 5; k++) push(DW'(k));
        tb_ready   = 1'b1;
        tb_flush   = 1'b0;
        pend_model = 1'b0;
        nreset     = 1'b1;
        #1;
        check({pfx, "_rd_first"}, 128'(bus.fifo_rd_en), 128'(1));
        cyc(1'b1, 1'b0);
        check({pfx, "_valid_c2"}, 128'(bus.out_valid), 128'(0));
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            check({pfx, "_valid"}, 128'(bus.out_valid), 128'(1));
            check({pfx, "_data"}, 128'(bus.out_data), 128'(k));
            cyc(1'b1, 1'b0);
        end
        check({pfx, "_valid_after"}, 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        int run, max_run, nvalid, max_bc, first, last, guard;

        // ---------------- reset ----------------
        #2 nreset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_rd_en", 128'(bus.fifo_rd_en), 128'(0));
        check("rst_count", 128'(bus.buf_count), 128'(0));
        check("rst_data", 128'(bus.out_data), 128'(0));

        // ---------------- 1: first stream after reset ----------------
        release_and_check("s1");

        // ---------------- 2: 100-entry stream, no bubbles ----------------
        for (int i = 0; i < 100; i++) push(DW'(32'h100 + i));
        obs.delete();
        run = 0; max_run = 0; nvalid = 0; max_bc = 0;
        for (int c = 0; c < 110; c++) begin
            cyc(1'b1, 1'b0);
            if (bus.out_valid) begin
                run++;
                nvalid++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (int'(bus.buf_count) > max_bc) max_bc = int'(bus.buf_count);
        end
        check("s2_run", 128'(max_run), 128'(100));
        check("s2_nvalid", 128'(nvalid), 128'(100));
        check("s2_max_count", 128'(max_bc), 128'(1));
        check_seq("s2", DW'(32'h100), 100);

        // ---------------- 3: backpressure ----------------
        obs.delete();
        tb_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(DW'(32'h200 + i));
        rd_cnt = 0;
        repeat (8) cyc(1'b0, 1'b0);
        check("s3_rd_pulses", 128'(rd_cnt), 128'(3));
        check("s3_count", 128'(bus.buf_count), 128'(3));
        check("s3_rd_stopped", 128'(bus.fifo_rd_en), 128'(0));
        check("s3_head", 128'(bus.out_data), 128'(32'h200));
        first = -1; last = -1; nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 0) check("s3_no_rd_at_full", 128'(s_rd_en), 128'(0));
            if (i == 1) check("s3_rd_resume", 128'(s_rd_en), 128'(1));
            if (s_valid) begin
                if (first < 0) first = i;
                last = i;
                nvalid++;
            end
        end
        check("s3_nvalid", 128'(nvalid), 128'(10));
        check("s3_no_gap", 128'(last - first), 128'(9));
        check_seq("s3", DW'(32'h200), 10);

        // ---------------- 4: random backpressure ----------------
        obs.delete();
        max_inflight = 0;
        for (int i = 0; i < 32; i++) push(DW'(32'h300 + i));
        guard = 0;
        while (obs.size() < 32 && guard < 400) begin
            cyc(1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        check_seq("s4", DW'(32'h300), 32);
        check("s4_inflight_le3", 128'(max_inflight <= 3), 128'(1));

        // ---------------- 5: flush with two held, one in flight ----------------
        repeat (2) cyc(1'b0, 1'b0);
        obs.delete();
        for (int i = 0; i < 10; i++) push(DW'(32'h400 + i));
        repeat (3) cyc(1'b0, 1'b0);
        check("s5_count_before", 128'(bus.buf_count), 128'(2));
        cyc(1'b0, 1'b1);
        check("s5_rd_blocked", 128'(s_rd_en), 128'(0));
        check("s5_count_after", 128'(bus.buf_count), 128'(0));
        check("s5_valid_after", 128'(bus.out_valid), 128'(0));
        guard = 0;
        while (obs.size() < 7 && guard < 50) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        check_seq("s5", DW'(32'h403), 7);

        // ---------------- 6: reset mid-stream ----------------
        repeat (2) cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) push(DW'(32'h500 + i));
        repeat (4) cyc(1'b0, 1'b0);
        check("s6_count_full", 128'(bus.buf_count), 128'(3));
        nreset = 1'b0;
        #1;
        check("s6_rst_valid", 128'(bus.out_valid), 128'(0));
        check("s6_rst_count", 128'(bus.buf_count), 128'(0));
        check("s6_rst_data", 128'(bus.out_data), 128'(0));
        check("s6_rst_rd_en", 128'(bus.fifo_rd_en), 128'(0));
        repeat (2) @(negedge clk);
        release_and_check("s6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
